// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end of the pipelined RISC-V core. It holds the PC,
//   issues one instruction-memory request at a time, and presents the fetched
//   instruction with its PC and PC+4 to the fetch/decode pipeline register.
//   When no real instruction is available it presents NOP_INSTR so the decode
//   register latches a bubble. Redirects from execute discard any wrong-path
//   fetch that is still in flight.
//
// Ports
//   clk              clock, all state updates on posedge
//   rst              synchronous active-high reset
//   stallF           hazard unit: hold current instruction and PC
//   PCSrcE           execute: redirect fetch this cycle
//   PCTargetE        execute: redirect target
//   imem_req_valid   request valid (only in ISSUE)
//   imem_req_addr    request address, always the PC register
//   imem_req_ready   memory accepts request
//   imem_resp_valid  response data valid (one per accepted request)
//   imem_resp_data   instruction word
//   PCounterF        PC of presented instruction
//   instr            presented instruction, NOP_INSTR when not valid
//   PCPlus4F         PCounterF + 4, wrapping
//   instr_validF     instr holds a real fetched instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallF,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic                  imem_req_valid,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_req_ready,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic [DATA_WIDTH-1:0] PCounterF,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] PCPlus4F,
   output logic                  instr_validF
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_instr;
   logic                  r_drop;

   logic                  w_handshake;
   logic                  w_resp_take;
   logic [DATA_WIDTH-1:0] w_pc_next;

   // The request is offered for the whole ISSUE state; address is the PC itself.
   assign imem_req_valid = (r_state == S_ISSUE);
   assign imem_req_addr  = r_pc;
   assign PCounterF      = r_pc;
   assign w_pc_next      = r_pc + PC_STEP;
   assign PCPlus4F       = w_pc_next;

   assign w_handshake = imem_req_valid & imem_req_ready;
   // A response only counts in WAIT and only when it is not a wrong-path fetch.
   assign w_resp_take = (r_state == S_WAIT) & imem_resp_valid & ~r_drop;

   // Presented instruction: redirect squashes, HOLD replays the latched word,
   // a live response is bypassed straight through in its arrival cycle.
   always_comb begin
      instr_validF = 1'b0;
      instr        = NOP_INSTR;
      if (PCSrcE) begin
         instr_validF = 1'b0;
         instr        = NOP_INSTR;
      end else if (r_state == S_HOLD) begin
         instr_validF = 1'b1;
         instr        = r_instr;
      end else if (w_resp_take) begin
         instr_validF = 1'b1;
         instr        = imem_resp_data;
      end else begin
         instr_validF = 1'b0;
         instr        = NOP_INSTR;
      end
   end

   // Fetch FSM, PC register, held instruction and wrong-path drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ISSUE;
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_drop  <= 1'b0;
      end else if (PCSrcE) begin
         // Redirect beats stall and normal advance in every state.
         r_pc <= PCTargetE;
         case (r_state)
            S_ISSUE: begin
               if (w_handshake) begin
                  // Old address was accepted this cycle; its response is wrong-path.
                  r_state <= S_WAIT;
                  r_drop  <= 1'b1;
               end else begin
                  r_state <= S_ISSUE;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  r_state <= S_ISSUE;
                  r_drop  <= 1'b0;
               end else begin
                  r_state <= S_WAIT;
                  r_drop  <= 1'b1;
               end
            end
            S_HOLD: begin
               r_state <= S_ISSUE;
               r_instr <= NOP_INSTR;
            end
            default: begin
               r_state <= S_ISSUE;
               r_drop  <= 1'b0;
            end
         endcase
      end else begin
         case (r_state)
            S_ISSUE: begin
               if (w_handshake) begin
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_ISSUE;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid && r_drop) begin
                  r_drop  <= 1'b0;
                  r_state <= S_ISSUE;
               end else if (imem_resp_valid && !stallF) begin
                  r_pc    <= w_pc_next;
                  r_state <= S_ISSUE;
               end else if (imem_resp_valid) begin
                  // Decode is stalled: park the word until it can be consumed.
                  r_instr <= imem_resp_data;
                  r_state <= S_HOLD;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_HOLD: begin
               if (!stallF) begin
                  r_pc    <= w_pc_next;
                  r_state <= S_ISSUE;
               end else begin
                  r_state <= S_HOLD;
               end
            end
            default: begin
               r_state <= S_ISSUE;
               r_drop  <= 1'b0;
            end
         endcase
      end
   end

endmodule
